// File: rtl/route_link_pkg.sv
// Purpose: shared widths, FSM state type and parity helper for the route-decision link transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package route_link_pkg;

  localparam int HDR_W   = 30;
  localparam int FRAME_W = 60;
  localparam int RSP_W   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Odd parity: returns the bit that makes the total count of ones odd.
  // Zero-extension of a narrower beat does not change its parity.
  function automatic logic odd_par(input logic [FRAME_W-1:0] v);
    return ~^v;
  endfunction

  // A beat width is legal only if the frame splits into whole beats.
  function automatic bit link_w_ok(input int w);
    return (w > 0) && (w <= FRAME_W) && ((FRAME_W % w) == 0);
  endfunction

endpackage

// File: rtl/route_link_ser.sv
// Purpose: serializes one 60-bit frame into FRAME_W/LINK_W beats, LSB beat first, with sof/eof/odd parity.
// Latency: load at cycle T drives beat 0 at T+1; one beat per cycle while link_ready is high.
// Backpressure: beat index and all link outputs hold while link_ready is low; done pulses on last-beat accept.
// Ports: clk, rst_n (sync, active-low); load/frame (start a frame); link_valid/link_ready/link_data/
//        link_sof/link_eof/link_par (beat link); done (last beat accepted this cycle).
module route_link_ser
  import route_link_pkg::*;
#(
  parameter int LINK_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               link_valid,
  input  logic               link_ready,
  output logic [LINK_W-1:0]  link_data,
  output logic               link_sof,
  output logic               link_eof,
  output logic               link_par,
  output logic               done
);

  localparam int BEATS = FRAME_W / LINK_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   beat;
  logic               active;
  logic               fire;
  logic               last;

  assign fire = active & link_ready;
  assign last = (beat == CNT_W'(BEATS - 1));
  assign done = fire & last;

  // The frame register shifts down one beat per accepted beat, so the
  // current beat is always the low LINK_W bits; it drains to zero at the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg  <= '0;
      beat   <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg  <= frame;
      beat   <= '0;
      active <= 1'b1;
    end else if (fire) begin
      shreg <= shreg >> LINK_W;
      if (last) begin
        beat   <= '0;
        active <= 1'b0;
      end else begin
        beat <= beat + CNT_W'(1);
      end
    end
  end

  assign link_valid = active;
  assign link_data  = shreg[LINK_W-1:0];
  assign link_sof   = active & (beat == '0);
  assign link_eof   = active & last;
  assign link_par   = active & odd_par(FRAME_W'(shreg[LINK_W-1:0]));

endmodule

// File: rtl/route_link_tx.sv
// Purpose: requester-side route-decision link transmitter: sends {req_b, req_a}, awaits a 3-bit decision or timeout.
// Latency: handshake at T, beat 0 at T+1, last beat at T+BEATS (link_ready high); result one cycle after decision/expiry.
// Backpressure: one request in flight; req_ready only in IDLE; result held in DONE until rsp_ready.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_a/req_b (request); link_* (beat link);
//        rsp_in_valid/rsp_in_data (decision from router); rsp_valid/rsp_ready/rsp_data/rsp_timeout (result); busy.
module route_link_tx
  import route_link_pkg::*;
#(
  parameter int LINK_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [HDR_W-1:0]  req_a,
  input  logic [HDR_W-1:0]  req_b,
  output logic              link_valid,
  input  logic              link_ready,
  output logic [LINK_W-1:0] link_data,
  output logic              link_sof,
  output logic              link_eof,
  output logic              link_par,
  input  logic              rsp_in_valid,
  input  logic [RSP_W-1:0]  rsp_in_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RSP_W-1:0]  rsp_data,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  if (!link_w_ok(LINK_W)) begin : g_bad_link_w
    $error("route_link_tx: LINK_W must divide the 60-bit frame");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("route_link_tx: TIMEOUT must be at least 1");
  end

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             load;
  logic             ser_done;

  assign load = (state == IDLE) & req_valid;

  route_link_ser #(
    .LINK_W (LINK_W)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .frame      ({req_b, req_a}),
    .link_valid (link_valid),
    .link_ready (link_ready),
    .link_data  (link_data),
    .link_sof   (link_sof),
    .link_eof   (link_eof),
    .link_par   (link_par),
    .done       (ser_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) state <= SEND;
        end
        SEND: begin
          if (ser_done) begin
            state <= WAIT_RSP;
            timer <= '0;
          end
        end
        WAIT_RSP: begin
          // A decision arriving in the expiry cycle takes priority over the timeout.
          if (rsp_in_valid) begin
            rsp_data    <= rsp_in_data;
            rsp_timeout <= 1'b0;
            state       <= DONE;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state       <= IDLE;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_route_link_tx.sv
// Purpose: directed, table-driven bench for route_link_tx (LINK_W=10 and LINK_W=60 instances, TIMEOUT=8).
// Latency: checks beat 0 at T+1, last beat at T+6, timeout after 8 wait cycles.
// Backpressure: exercises link stall, held results and reset mid-frame.
module tb_route_link_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // LINK_W = 10 instance
  logic        req_valid, req_ready;
  logic [29:0] req_a, req_b;
  logic        link_valid, link_ready;
  logic [9:0]  link_data;
  logic        link_sof, link_eof, link_par;
  logic        rsp_in_valid;
  logic [2:0]  rsp_in_data;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_data;
  logic        rsp_timeout, busy;

  // LINK_W = 60 instance
  logic        req_valid_w, req_ready_w;
  logic [29:0] req_a_w, req_b_w;
  logic        link_valid_w, link_ready_w;
  logic [59:0] link_data_w;
  logic        link_sof_w, link_eof_w, link_par_w;
  logic        rsp_in_valid_w;
  logic [2:0]  rsp_in_data_w;
  logic        rsp_valid_w, rsp_ready_w;
  logic [2:0]  rsp_data_w;
  logic        rsp_timeout_w, busy_w;

  route_link_tx #(.LINK_W(10), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .link_valid(link_valid), .link_ready(link_ready), .link_data(link_data),
    .link_sof(link_sof), .link_eof(link_eof), .link_par(link_par),
    .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  route_link_tx #(.LINK_W(60), .TIMEOUT(8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_a(req_a_w), .req_b(req_b_w),
    .link_valid(link_valid_w), .link_ready(link_ready_w), .link_data(link_data_w),
    .link_sof(link_sof_w), .link_eof(link_eof_w), .link_par(link_par_w),
    .rsp_in_valid(rsp_in_valid_w), .rsp_in_data(rsp_in_data_w),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w), .rsp_data(rsp_data_w),
    .rsp_timeout(rsp_timeout_w), .busy(busy_w)
  );

  int vecs;
  int errs;

  // Beat monitor: counts accepted beats and accepted eof beats.
  logic mon_clr;
  int   beat_cnt;
  int   eof_cnt;
  always @(posedge clk) begin
    if (mon_clr) begin
      beat_cnt <= 0;
      eof_cnt  <= 0;
    end else if (link_valid && link_ready) begin
      beat_cnt <= beat_cnt + 1;
      if (link_eof) eof_cnt <= eof_cnt + 1;
    end
  end

  typedef struct {
    logic [29:0] a;
    logic [29:0] b;
    int          beat;
    logic [9:0]  data;
    logic        sof;
    logic        eof;
    logic        par;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input logic [9:0] d, input logic s, input logic e, input logic p);
    chk(name, {50'd0, link_valid, link_data, link_sof, link_eof, link_par}, {50'd0, 1'b1, d, s, e, p});
  endtask

  task automatic pulse_mon_clr();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Waits (bounded) for IDLE, handshakes, then scrambles the operands.
  // Returns at the negedge of cycle T+1 where beat 0 must be visible.
  task automatic start_req(input logic [29:0] a, input logic [29:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = ~b;
  endtask

  task automatic consume(input string name);
    rsp_ready = 1'b1;
    chk({name, "_no_turnaround"}, {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_idle"}, {61'd0, req_ready, rsp_valid, busy}, {61'd0, 3'b100});
  endtask

  task automatic respond(input string name, input logic [2:0] d);
    rsp_in_valid = 1'b1;
    rsp_in_data  = d;
    @(negedge clk);
    rsp_in_valid = 1'b0;
    rsp_in_data  = 3'b000;
    chk({name, "_rsp"}, {59'd0, rsp_valid, rsp_timeout, rsp_data}, {59'd0, 1'b1, 1'b0, d});
    consume(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    mon_clr = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; link_ready = 1'b1;
    rsp_in_valid = 1'b0; rsp_in_data = '0; rsp_ready = 1'b0;
    req_valid_w = 1'b0; req_a_w = '0; req_b_w = '0; link_ready_w = 1'b1;
    rsp_in_valid_w = 1'b0; rsp_in_data_w = '0; rsp_ready_w = 1'b0;

    // beat table: {a, b, beat, data, sof, eof, par}
    tbl[0]  = '{30'h1,        30'h0,        0, 10'h001, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{30'h1,        30'h0,        1, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{30'h1,        30'h0,        2, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{30'h1,        30'h0,        3, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{30'h1,        30'h0,        4, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{30'h1,        30'h0,        5, 10'h000, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{30'h3FFFFFFF, 30'h15555555, 0, 10'h3FF, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{30'h3FFFFFFF, 30'h15555555, 1, 10'h3FF, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{30'h3FFFFFFF, 30'h15555555, 2, 10'h3FF, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{30'h3FFFFFFF, 30'h15555555, 3, 10'h155, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{30'h3FFFFFFF, 30'h15555555, 4, 10'h155, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{30'h3FFFFFFF, 30'h15555555, 5, 10'h155, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{30'h00100401, 30'h3FF00000, 0, 10'h001, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{30'h00100401, 30'h3FF00000, 1, 10'h001, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{30'h00100401, 30'h3FF00000, 2, 10'h001, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{30'h00100401, 30'h3FF00000, 3, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{30'h00100401, 30'h3FF00000, 4, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{30'h00100401, 30'h3FF00000, 5, 10'h3FF, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset", {43'd0, req_ready, busy, link_valid, link_data, link_sof, link_eof, link_par,
                  rsp_valid, rsp_data, rsp_timeout},
                 {43'd0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0});
    chk("reset_w", {59'd0, req_ready_w, busy_w, link_valid_w, rsp_valid_w, rsp_timeout_w},
                   {59'd0, 5'b10000});
    rst_n = 1'b1;
    mon_clr = 1'b0;
    @(negedge clk);

    // Table-driven frames, link_ready held high: beat i visible at T+1+i
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].beat == 0) start_req(tbl[i].a, tbl[i].b);
      chk_beat($sformatf("tbl%0d_beat%0d", i, tbl[i].beat), tbl[i].data, tbl[i].sof, tbl[i].eof, tbl[i].par);
      @(negedge clk);
      if (tbl[i].eof) begin
        chk($sformatf("tbl%0d_wait", i), {62'd0, link_valid, busy}, {62'd0, 2'b01});
        respond($sformatf("tbl%0d", i), 3'(i / 6 + 3));
      end
    end

    // Stall on beat 2 for three cycles
    pulse_mon_clr();
    start_req(30'h00100401, 30'h3FF00000);
    chk_beat("st_b0", 10'h001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("st_b1", 10'h001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    link_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_beat($sformatf("st_hold%0d", k), 10'h001, 1'b0, 1'b0, 1'b0);
      if (k == 3) link_ready = 1'b1;
      @(negedge clk);
    end
    chk_beat("st_b3", 10'h000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_beat("st_b4", 10'h000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_beat("st_b5", 10'h3FF, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("st_beat_count", 64'(beat_cnt), 64'd6);
    chk("st_eof_count", 64'(eof_cnt), 64'd1);

    // Response two cycles into the wait, held with rsp_ready low for 5 cycles
    repeat (2) @(negedge clk);
    chk("rsp_still_waiting", {62'd0, rsp_valid, busy}, {62'd0, 2'b01});
    rsp_in_valid = 1'b1;
    rsp_in_data  = 3'b101;
    @(negedge clk);
    rsp_in_valid = 1'b0;
    rsp_in_data  = 3'b000;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rsp_hold%0d", k), {59'd0, rsp_valid, rsp_timeout, rsp_data}, {59'd0, 1'b1, 1'b0, 3'b101});
      @(negedge clk);
    end
    consume("rsp");

    // Timeout after 8 wait cycles, then a late response is ignored
    start_req(30'h2, 30'h0);
    repeat (6) @(negedge clk);
    repeat (7) @(negedge clk);
    chk("to_last_wait", {62'd0, rsp_valid, busy}, {62'd0, 2'b01});
    @(negedge clk);
    chk("to_done", {59'd0, rsp_valid, rsp_timeout, rsp_data}, {59'd0, 1'b1, 1'b1, 3'b000});
    rsp_in_valid = 1'b1;
    rsp_in_data  = 3'b111;
    repeat (2) @(negedge clk);
    chk("to_late_ignored", {59'd0, rsp_valid, rsp_timeout, rsp_data}, {59'd0, 1'b1, 1'b1, 3'b000});
    consume("to");
    @(negedge clk);
    chk("idle_ignores_rsp", {61'd0, req_ready, busy, rsp_valid}, {61'd0, 3'b100});
    rsp_in_valid = 1'b0;
    rsp_in_data  = 3'b000;

    // Response in the expiry cycle wins over the timeout
    start_req(30'h2, 30'h0);
    repeat (6) @(negedge clk);
    repeat (7) @(negedge clk);
    rsp_in_valid = 1'b1;
    rsp_in_data  = 3'b110;
    @(negedge clk);
    rsp_in_valid = 1'b0;
    rsp_in_data  = 3'b000;
    chk("expiry_rsp_wins", {59'd0, rsp_valid, rsp_timeout, rsp_data}, {59'd0, 1'b1, 1'b0, 3'b110});
    consume("expiry");

    // Reset during beat 3 abandons the frame; next frame starts cleanly
    pulse_mon_clr();
    start_req(30'h00100401, 30'h3FF00000);
    repeat (3) @(negedge clk);
    chk_beat("rs_b3", 10'h000, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rs_abort", {60'd0, link_valid, req_ready, busy, rsp_valid}, {60'd0, 4'b0100});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_no_eof", 64'(eof_cnt), 64'd0);
    chk("rs_quiet", {62'd0, link_valid, rsp_valid}, 64'd0);
    start_req(30'h1, 30'h0);
    chk_beat("rs_new_b0", 10'h001, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    repeat (8) @(negedge clk);
    chk("rs_new_timeout", {59'd0, rsp_valid, rsp_timeout, rsp_data}, {59'd0, 1'b1, 1'b1, 3'b000});
    consume("rs");

    // LINK_W = 60: single beat, sof and eof together; 45 ones is already odd so parity is 0
    req_valid_w = 1'b1;
    req_a_w     = 30'h3FFFFFFF;
    req_b_w     = 30'h15555555;
    @(negedge clk);
    req_valid_w = 1'b0;
    req_a_w     = 30'h0;
    req_b_w     = 30'h0;
    chk("w60_beat", {link_valid_w, link_data_w, link_sof_w, link_eof_w, link_par_w},
                    {1'b1, 30'h15555555, 30'h3FFFFFFF, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    chk("w60_wait", {62'd0, link_valid_w, busy_w}, {62'd0, 2'b01});
    rsp_in_valid_w = 1'b1;
    rsp_in_data_w  = 3'b010;
    @(negedge clk);
    rsp_in_valid_w = 1'b0;
    chk("w60_rsp", {59'd0, rsp_valid_w, rsp_timeout_w, rsp_data_w}, {59'd0, 1'b1, 1'b0, 3'b010});
    rsp_ready_w = 1'b1;
    @(negedge clk);
    rsp_ready_w = 1'b0;
    chk("w60_idle", {61'd0, req_ready_w, rsp_valid_w, busy_w}, {61'd0, 3'b100});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
